// File: rtl/force_apply_pkg.sv
// Shared physics package for the force_apply slice.
// Holds the frame FSM state type and the signed clamp helper used by
// every saturating datapath element.
package force_apply_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCUM  = 2'd1,
      UPDATE = 2'd2
   } state_t;

   // Clamp a signed value into the range representable in 'width' bits.
   // The result is still 32 bits wide; callers truncate to 'width'.
   function automatic logic signed [31:0] sat_clamp(input logic signed [31:0] value,
                                                    input int width);
      logic signed [31:0] max_v;
      logic signed [31:0] min_v;
      max_v = (32'sd1 <<< (width - 1)) - 32'sd1;
      min_v = -(32'sd1 <<< (width - 1));
      if (value > max_v) begin
         return max_v;
      end
      if (value < min_v) begin
         return min_v;
      end
      return value;
   endfunction

endpackage

// File: rtl/force_apply_sat_add.sv
// sat_add: signed saturating adder.
// Ports:
//   a_in, b_in : signed W_IN-bit operands
//   sum_out    : signed W_OUT-bit sum, clamped to the W_OUT range
// The sum is formed one bit wider than the operands so it can never wrap
// before clamping. W_OUT may be narrower than W_IN (position path).
module sat_add
   import force_apply_pkg::*;
#(
   parameter int W_IN  = 12,
   parameter int W_OUT = 12
)(
   input  logic signed [W_IN-1:0]  a_in,
   input  logic signed [W_IN-1:0]  b_in,
   output logic signed [W_OUT-1:0] sum_out
);

   logic signed [W_IN:0] sum_wide;

   assign sum_wide = (W_IN + 1)'(a_in) + (W_IN + 1)'(b_in);
   assign sum_out  = W_OUT'(sat_clamp(32'(sum_wide), W_OUT));

endmodule

// File: rtl/force_apply.sv
// force_apply: accumulates one frame of per-node forces into velocities,
// then integrates velocity into position one node per cycle and damps it.
// Ports:
//   clk_in, rst_in          : clock, synchronous active-high reset
//   load_in, nodes_init_in  : load initial positions (IDLE only), zero velocities
//   begin_in                : start a force frame (IDLE only)
//   force_x_in/force_y_in   : force beat for the next node, qualified by force_in_valid
//   result_in               : end of frame, starts the position update
//   nodes_out, vel_out      : registered positions / velocities, [axis][node]
//   busy_out                : high while accumulating or updating
//   done_out                : one-cycle pulse when the update completes
//   count_err_out           : last frame did not carry exactly NUM_NODES beats
module force_apply
   import force_apply_pkg::*;
#(
   parameter int NUM_NODES     = 10,
   parameter int POSITION_SIZE = 8,
   parameter int FORCE_SIZE    = 8,
   parameter int VELOCITY_SIZE = 12,
   parameter int DT_SHIFT      = 4,
   parameter int DAMP_SHIFT    = 3
)(
   input  logic                                               clk_in,
   input  logic                                               rst_in,
   input  logic                                               load_in,
   input  logic [1:0][NUM_NODES-1:0][POSITION_SIZE-1:0]       nodes_init_in,
   input  logic                                               begin_in,
   input  logic signed [FORCE_SIZE-1:0]                       force_x_in,
   input  logic signed [FORCE_SIZE-1:0]                       force_y_in,
   input  logic                                               force_in_valid,
   input  logic                                               result_in,
   output logic [1:0][NUM_NODES-1:0][POSITION_SIZE-1:0]       nodes_out,
   output logic [1:0][NUM_NODES-1:0][VELOCITY_SIZE-1:0]       vel_out,
   output logic                                               busy_out,
   output logic                                               done_out,
   output logic                                               count_err_out
);

   localparam int IDX_W = $clog2(NUM_NODES + 1);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NODES - 1);
   localparam logic [IDX_W-1:0] FULL_IDX = IDX_W'(NUM_NODES);

   state_t                          state_reg, state_next;
   logic [IDX_W-1:0]                idx_reg;
   logic [IDX_W-1:0]                idx_after;
   logic [IDX_W-1:0]                node_sel;
   logic                            done_reg;
   logic                            err_reg;
   logic                            beat_take;
   logic                            beat_drop;

   logic signed [POSITION_SIZE-1:0] pos_reg  [2][NUM_NODES];
   logic signed [VELOCITY_SIZE-1:0] vel_reg  [2][NUM_NODES];
   logic signed [FORCE_SIZE-1:0]    force_in [2];
   logic signed [VELOCITY_SIZE-1:0] vel_cur  [2];
   logic signed [VELOCITY_SIZE-1:0] vel_acc  [2];
   logic signed [VELOCITY_SIZE-1:0] vel_damp [2];
   logic signed [POSITION_SIZE-1:0] pos_new  [2];

   assign force_in[0] = force_x_in;
   assign force_in[1] = force_y_in;

   // Beats past the last node are dropped; the index never exceeds NUM_NODES,
   // so the clamp only keeps the mux in range for that extra state.
   assign beat_take = (state_reg == ACCUM) && force_in_valid && (idx_reg < FULL_IDX);
   assign beat_drop = (state_reg == ACCUM) && force_in_valid && (idx_reg == FULL_IDX);
   assign idx_after = beat_take ? idx_reg + IDX_W'(1) : idx_reg;
   assign node_sel  = (idx_reg < FULL_IDX) ? idx_reg : '0;

   // One accumulate / integrate / damp datapath per axis, shared by all nodes.
   for (genvar gi = 0; gi < 2; gi++) begin : g_axis
      logic signed [VELOCITY_SIZE-1:0] force_ext;
      logic signed [VELOCITY_SIZE-1:0] pos_ext;
      logic signed [VELOCITY_SIZE-1:0] vel_step;

      assign vel_cur[gi]  = vel_reg[gi][node_sel];
      assign force_ext    = VELOCITY_SIZE'(force_in[gi]);
      assign pos_ext      = VELOCITY_SIZE'(pos_reg[gi][node_sel]);
      assign vel_step     = vel_cur[gi] >>> DT_SHIFT;
      // Result lies between 0 and vel_cur, so it cannot overflow.
      assign vel_damp[gi] = vel_cur[gi] - (vel_cur[gi] >>> DAMP_SHIFT);

      sat_add #(.W_IN(VELOCITY_SIZE), .W_OUT(VELOCITY_SIZE)) u_vel_add (
         .a_in    (vel_cur[gi]),
         .b_in    (force_ext),
         .sum_out (vel_acc[gi])
      );

      sat_add #(.W_IN(VELOCITY_SIZE), .W_OUT(POSITION_SIZE)) u_pos_add (
         .a_in    (pos_ext),
         .b_in    (vel_step),
         .sum_out (pos_new[gi])
      );
   end

   always_comb begin
      state_next = state_reg;
      busy_out   = 1'b0;
      case (state_reg)
         IDLE: begin
            if (!load_in && begin_in) begin
               state_next = ACCUM;
            end
         end
         ACCUM: begin
            busy_out = 1'b1;
            if (result_in) begin
               state_next = UPDATE;
            end
         end
         UPDATE: begin
            busy_out = 1'b1;
            if (idx_reg == LAST_IDX) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_reg <= IDLE;
         idx_reg   <= '0;
         done_reg  <= 1'b0;
         err_reg   <= 1'b0;
         for (int a = 0; a < 2; a++) begin
            for (int n = 0; n < NUM_NODES; n++) begin
               pos_reg[a][n] <= '0;
               vel_reg[a][n] <= '0;
            end
         end
      end else begin
         state_reg <= state_next;
         done_reg  <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (load_in) begin
                  for (int a = 0; a < 2; a++) begin
                     for (int n = 0; n < NUM_NODES; n++) begin
                        pos_reg[a][n] <= nodes_init_in[a][n];
                        vel_reg[a][n] <= '0;
                     end
                  end
               end else if (begin_in) begin
                  idx_reg <= '0;
                  err_reg <= 1'b0;
               end
            end
            ACCUM: begin
               if (beat_take) begin
                  for (int a = 0; a < 2; a++) begin
                     vel_reg[a][node_sel] <= vel_acc[a];
                  end
               end
               if (beat_drop) begin
                  err_reg <= 1'b1;
               end
               idx_reg <= idx_after;
               // A beat on the same cycle as result_in is already counted in idx_after.
               if (result_in) begin
                  idx_reg <= '0;
                  if (idx_after != FULL_IDX) begin
                     err_reg <= 1'b1;
                  end
               end
            end
            UPDATE: begin
               for (int a = 0; a < 2; a++) begin
                  pos_reg[a][node_sel] <= pos_new[a];
                  vel_reg[a][node_sel] <= vel_damp[a];
               end
               if (idx_reg == LAST_IDX) begin
                  idx_reg  <= '0;
                  done_reg <= 1'b1;
               end else begin
                  idx_reg <= idx_reg + IDX_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

   for (genvar gi = 0; gi < 2; gi++) begin : g_out_axis
      for (genvar gn = 0; gn < NUM_NODES; gn++) begin : g_out_node
         assign nodes_out[gi][gn] = pos_reg[gi][gn];
         assign vel_out[gi][gn]   = vel_reg[gi][gn];
      end
   end

   assign done_out      = done_reg;
   assign count_err_out = err_reg;

endmodule
